// File: rtl/pipe_elastic_reg_pkg.sv
// Shared types and elaboration-time helpers for the elastic pipeline register.
package pipe_elastic_reg_pkg;

  // Push/pop activity of one cycle, encoded as {pop, push}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

  function automatic int unsigned ptr_width(input int unsigned depth);
    if (depth <= 32'd1) begin
      return 32'd1;
    end else begin
      return $clog2(depth);
    end
  endfunction

  function automatic bit depth_legal(input int unsigned depth);
    case (depth)
      32'd1, 32'd2, 32'd4, 32'd8: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_elastic_reg_if.sv
// Upstream/downstream handshake bundle of the elastic pipeline register.
interface pipe_elastic_reg_if #(
  parameter int unsigned DATA_WD = 147,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned CNT_WD  = 16
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic               in_valid;
  logic [DATA_WD-1:0] in_data;
  logic               in_ready;
  logic               out_valid;
  logic [DATA_WD-1:0] out_data;
  logic               out_ready;
  logic [CW-1:0]      count;
  logic               stall_req;
  logic [CNT_WD-1:0]  stall_cnt;

  // Environment side: produces payloads and consumes the head.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count, stall_req, stall_cnt
  );

  // Buffer side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count, stall_req, stall_cnt
  );

endinterface

// File: rtl/pipe_elastic_reg.sv
// DEPTH-entry circular-buffer stage register with zeroed bubbles and a saturating stall counter.
module pipe_elastic_reg
  import pipe_elastic_reg_pkg::*;
#(
  parameter int unsigned DATA_WD = 147,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned CNT_WD  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  pipe_elastic_reg_if.slave bus
);

  localparam int unsigned       PTR_WD   = ptr_width(DEPTH);
  localparam int unsigned       CW       = $clog2(DEPTH + 1);
  localparam logic [PTR_WD-1:0] PTR_LAST = PTR_WD'(DEPTH - 1);
  localparam logic [CW-1:0]     CNT_FULL = CW'(DEPTH);

  logic [DATA_WD-1:0] mem_q [DEPTH];
  logic [PTR_WD-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_WD-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [CNT_WD-1:0]  stall_cnt_q, stall_cnt_d;

  logic               in_ready_s;
  logic               out_valid_s;
  logic               push_s;
  logic               pop_s;
  logic               stall_req_s;
  logic [DATA_WD-1:0] out_data_s;
  op_e                op_s;

  // Explicit wrap so non-power-of-two pointer ranges (DEPTH = 1) stay modulo DEPTH.
  function automatic logic [PTR_WD-1:0] ptr_inc(input logic [PTR_WD-1:0] p);
    if (p == PTR_LAST) begin
      return '0;
    end else begin
      return p + PTR_WD'(1);
    end
  endfunction

  // Readiness depends on occupancy only, never on out_ready.
  assign in_ready_s  = (count_q < CNT_FULL);
  assign out_valid_s = (count_q != '0);
  assign push_s      = bus.in_valid & in_ready_s;
  assign pop_s       = out_valid_s & bus.out_ready;
  assign stall_req_s = bus.in_valid & ~in_ready_s;
  assign op_s        = op_e'({pop_s, push_s});

  // Pointer and occupancy next state; flush overrides any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      case (op_s)
        OP_PUSH: begin
          wr_ptr_d = ptr_inc(wr_ptr_q);
          count_d  = count_q + CW'(1);
        end
        OP_POP: begin
          rd_ptr_d = ptr_inc(rd_ptr_q);
          count_d  = count_q - CW'(1);
        end
        OP_BOTH: begin
          wr_ptr_d = ptr_inc(wr_ptr_q);
          rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        OP_IDLE: begin
          count_d  = count_q;
        end
        default: begin
          count_d  = count_q;
        end
      endcase
    end
  end

  // Saturating stall counter, deliberately blind to flush.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_req_s && (stall_cnt_q != {CNT_WD{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_WD'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Payload storage; contents are don't-care once count marks them empty.
  always_ff @(posedge clk) begin
    if (push_s && !flush) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

  // Bubbles present all-zero so downstream enables stay low.
  always_comb begin
    out_data_s = '0;
    if (out_valid_s) begin
      out_data_s = mem_q[rd_ptr_q];
    end else begin
      out_data_s = '0;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_data  = out_data_s;
  assign bus.count     = count_q;
  assign bus.stall_req = stall_req_s;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_elastic_reg.sv
// Scoreboard bench for pipe_elastic_reg: directed pushes feed an expected queue, a monitor checks pops.
module tb_pipe_elastic_reg;

  localparam int DW    = 147;
  localparam int DEP   = 2;
  localparam int SW    = 4;
  localparam int SMAX  = (1 << SW) - 1;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  pipe_elastic_reg_if #(.DATA_WD(DW), .DEPTH(DEP), .CNT_WD(SW)) bus ();

  pipe_elastic_reg #(.DATA_WD(DW), .DEPTH(DEP), .CNT_WD(SW)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q [$];
  int m_cnt   = 0;
  int m_stall = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every pop is compared with the scoreboard head; bubbles must be zero.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.out_valid === 1'b1) begin
        if (bus.out_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pop_unexpected: got %0h expected no entry", bus.out_data);
          end else begin
            chk("pop_data", bus.out_data, exp_q.pop_front());
          end
        end
      end else begin
        chk("bubble_zero", bus.out_data, '0);
      end
    end
  end

  // One cycle of stimulus; checks control outputs against the occupancy model.
  task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy,
                      input logic fl, output bit acc);
    bit rdy;
    bit pop;
    @(posedge clk);
    #1;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    flush         = fl;
    @(negedge clk);
    rdy = (m_cnt < DEP);
    chk("count",     bus.count,     m_cnt);
    chk("in_ready",  bus.in_ready,  rdy);
    chk("out_valid", bus.out_valid, m_cnt != 0);
    chk("stall_req", bus.stall_req, iv & !rdy);
    chk("stall_cnt", bus.stall_cnt, m_stall);
    acc = iv && rdy && !fl;
    pop = (m_cnt != 0) && ordy && !fl;
    if (iv && !rdy && (m_stall < SMAX)) m_stall++;
    if (fl) begin
      m_cnt = 0;
      exp_q.delete();
    end else begin
      if (acc) exp_q.push_back(d);
      m_cnt = m_cnt + int'(acc) - int'(pop);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    int d;
    int cyc;
    bus.in_valid  = 1'b1;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset state with in_valid held high.
    repeat (2) @(negedge clk);
    chk("rst_count",     bus.count,     0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data",  bus.out_data,  0);
    chk("rst_in_ready",  bus.in_ready,  1);
    chk("rst_stall_req", bus.stall_req, 0);
    chk("rst_stall_cnt", bus.stall_cnt, 0);
    #2;
    rst = 1'b1;
    bus.in_valid = 1'b0;

    // Single push, visible the following cycle.
    step(1'b1, 'h1, 1'b0, 1'b0, acc);
    step(1'b0, '0, 1'b0, 1'b0, acc);
    chk("t032_data",  bus.out_data, 'h1);
    chk("t032_count", bus.count,    1);
    step(1'b0, '0, 1'b1, 1'b0, acc);

    // Asynchronous reset mid-transfer, push on first posedge after release.
    step(1'b1, 'h11, 1'b0, 1'b0, acc);
    step(1'b1, 'h22, 1'b0, 1'b0, acc);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #2;
    chk("t029_rst_count", bus.count,     0);
    chk("t029_rst_valid", bus.out_valid, 0);
    chk("t029_rst_ready", bus.in_ready,  1);
    m_cnt = 0;
    m_stall = 0;
    exp_q.delete();
    @(negedge clk);
    #2;
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 'h33;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t029_first_count", bus.count,    1);
    chk("t029_first_data",  bus.out_data, 'h33);
    m_cnt = 1;
    exp_q.push_back('h33);
    step(1'b0, '0, 1'b1, 1'b0, acc);

    // Full buffer refuses 0xC and counts two stall cycles.
    step(1'b1, 'hA, 1'b0, 1'b0, acc);
    step(1'b1, 'hB, 1'b0, 1'b0, acc);
    step(1'b1, 'hC, 1'b0, 1'b0, acc);
    step(1'b1, 'hC, 1'b0, 1'b0, acc);
    step(1'b0, '0, 1'b0, 1'b0, acc);
    chk("t033_stall_cnt", bus.stall_cnt, 2);
    chk("t033_head",      bus.out_data,  'hA);
    step(1'b0, '0, 1'b1, 1'b0, acc);
    step(1'b0, '0, 1'b1, 1'b0, acc);

    // Full with push and pop together: pop only, push next cycle.
    step(1'b1, 'h41, 1'b0, 1'b0, acc);
    step(1'b1, 'h42, 1'b0, 1'b0, acc);
    step(1'b1, 'h43, 1'b1, 1'b0, acc);
    step(1'b1, 'h43, 1'b0, 1'b0, acc);
    step(1'b0, '0, 1'b0, 1'b0, acc);
    chk("t034_count", bus.count, 2);
    step(1'b0, '0, 1'b1, 1'b0, acc);
    step(1'b0, '0, 1'b1, 1'b0, acc);

    // Flush beats a simultaneous push.
    step(1'b1, 'h51, 1'b0, 1'b0, acc);
    step(1'b1, 'h52, 1'b0, 1'b0, acc);
    step(1'b1, 'h53, 1'b0, 1'b1, acc);
    step(1'b0, '0, 1'b0, 1'b0, acc);
    chk("t035_count", bus.count,     0);
    chk("t035_valid", bus.out_valid, 0);
    chk("t035_data",  bus.out_data,  0);

    // Streaming 0..9 with toggling out_ready; pointers wrap several times.
    d = 0;
    cyc = 0;
    while ((d < 10) && (cyc < 60)) begin
      step(1'b1, DW'(d), (cyc % 2) == 1, 1'b0, acc);
      if (acc) d++;
      cyc++;
    end
    chk("t036_all_pushed", d, 10);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, acc);
    chk("t036_drained", exp_q.size(), 0);
    chk("t036_count",   bus.count,    0);

    // Long stall drives the counter to all-ones, where it must stay.
    step(1'b1, 'hE1, 1'b0, 1'b0, acc);
    step(1'b1, 'hE2, 1'b0, 1'b0, acc);
    for (int i = 0; i < 22; i++) step(1'b1, 'hEE, 1'b0, 1'b0, acc);
    chk("t036_sat", bus.stall_cnt, SMAX);
    step(1'b1, 'hEE, 1'b0, 1'b1, acc);
    step(1'b0, '0, 1'b0, 1'b0, acc);
    chk("t036_sat_after_flush", bus.stall_cnt, SMAX);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_elastic_reg.md
PIPE_ELASTIC_REG -- requirements
Module: pipe_elastic_reg

Interface
REQ-001 Parameter DATA_WD, default 147, SHALL set the payload width (the EX->DC->MEM bus width).
REQ-002 Parameter DEPTH, default 2, SHALL set the buffer entries; legal values are 1, 2, 4 and 8.
REQ-003 Parameter CNT_WD, default 16, SHALL set the stall-counter width.
REQ-004 clk  input  1  SHALL be the only clock; all state updates on posedge clk.
REQ-005 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-006 flush  input  1  SHALL be a synchronous pipeline flush.
REQ-007 in_valid  input  1  SHALL mean the upstream payload is valid.
REQ-008 in_data  input  DATA_WD  SHALL carry the upstream payload.
REQ-009 in_ready  output  1  SHALL mean the stage accepts a push this cycle.
REQ-010 out_valid  output  1  SHALL mean the head entry is valid.
REQ-011 out_data  output  DATA_WD  SHALL carry the head payload.
REQ-012 out_ready  input  1  SHALL mean downstream consumes the head this cycle.
REQ-013 count  output  $clog2(DEPTH+1)  SHALL give the current occupancy.
REQ-014 stall_req  output  1  SHALL request an upstream stall from the stall controller.
REQ-015 stall_cnt  output  CNT_WD  SHALL give the saturating count of cycles with stall_req high.

Function
REQ-016 Storage SHALL be a DEPTH-entry circular buffer with wr_ptr, rd_ptr and count; both pointers wrap modulo DEPTH.
REQ-017 in_ready SHALL equal (count < DEPTH) and SHALL NOT depend combinationally on out_ready or in_valid.
REQ-018 Push SHALL occur when in_valid & in_ready; pop SHALL occur when out_valid & out_ready.
REQ-019 Pushed data SHALL first appear on out_data the cycle after the push (latency 1, no fall-through when empty).
REQ-020 Full with pop requested: push SHALL be refused that cycle; the pop proceeds and in_ready rises the next cycle.
REQ-021 Simultaneous push and pop when 0 < count < DEPTH: count SHALL be unchanged and both pointers SHALL advance.
REQ-022 out_valid SHALL equal (count != 0); out_data SHALL be all-zero whenever out_valid = 0, so bubbles carry rf_we = 0 and data_ram_en = 0.
REQ-023 Ordering SHALL be strict FIFO; no entry is dropped or duplicated except by flush.
REQ-024 flush SHALL set count, wr_ptr and rd_ptr to 0 next cycle, with priority over any push or pop that cycle; entry contents need not be cleared.
REQ-025 stall_req SHALL equal in_valid & ~in_ready.
REQ-026 stall_cnt SHALL increment by 1 each cycle stall_req = 1, saturate at all-ones, and be unaffected by flush.
REQ-027 With DEPTH = 1 the block SHALL act as a single pipeline register that accepts a new push only in a cycle where count = 0.

Reset
REQ-028 rst low SHALL asynchronously force count = 0, wr_ptr = 0, rd_ptr = 0 and stall_cnt = 0; consequently out_valid = 0, out_data = 0, in_ready = 1 and stall_req = in_valid & 0 = 0.
REQ-029 Reset asserted mid-transfer SHALL discard all entries; the first push after release SHALL be accepted on the first posedge where rst is high.

Structure
REQ-030 DATA_WD values for each stage bus (EX_TO_DC_WD, DC_TO_MEM_WD) and the stall-bus width SHALL stay in the shared lib/defines.vh; the block itself holds no stage-specific constants.
REQ-031 The block SHALL have no sub-module; storage SHALL be an inline flop array, with pointer and counter logic in the same module.

Verification
REQ-032 Reset, then push A=0x1 in cycle 0 -> out_valid = 1 and out_data = 0x1 in cycle 1, count = 1.
REQ-033 DEPTH = 2, out_ready = 0, push 0xA, 0xB, 0xC -> 0xC refused, in_ready = 0, stall_req = 1, stall_cnt increments to 1 and then 2 over 2 held cycles; after release the pops return 0xA then 0xB.
REQ-034 Full buffer, in_valid = 1 and out_ready = 1 together -> pop only that cycle, count goes 2 -> 1, push accepted the next cycle.
REQ-035 count = 2 with flush and in_valid asserted together -> next cycle count = 0, out_valid = 0, out_data = 0; the flushed push is lost.
REQ-036 Continuous push/pop of 0..9 with out_ready toggling -> output sequence exactly 0..9, pointer wrap checked; stall_cnt forced to all-ones stays saturated under stall.
